// File: rtl/adc_spi_responder_if.sv
// SPI link between the ADC controller (master) and the ADC emulator (slave).
//   iSCLK    : serial clock from the controller
//   iCS_n    : active-low chip select from the controller
//   iDIN     : command/address bit from the controller
//   oDOUT    : serial conversion result back to the controller
//   oDOUT_EN : 1 while the responder drives oDOUT (frame active)
interface adc_spi_responder_if;
  logic iSCLK;
  logic iCS_n;
  logic iDIN;
  logic oDOUT;
  logic oDOUT_EN;

  modport master (
    output iSCLK, iCS_n, iDIN,
    input  oDOUT, oDOUT_EN
  );

  modport slave (
    input  iSCLK, iCS_n, iDIN,
    output oDOUT, oDOUT_EN
  );
endinterface

// File: rtl/adc_spi_responder.sv
// Cycle-accurate emulator of an 8-channel 12-bit serial ADC. The SPI lines are
// oversampled on clk (no SCLK-clocked logic). Each frame shifts out
// LEAD_ZEROS zeros followed by the DATA_W-bit sample of the selected channel;
// the address sent on DIN during rising edges 3..5 selects the next frame.
// Ports:
//   clk, iRST     : system clock, synchronous active-high reset
//   spi           : SPI slave side (iSCLK, iCS_n, iDIN in; oDOUT, oDOUT_EN out)
//   iWR/iWR_ADDR/iWR_DATA : write port into the channel sample bank
//   oCH           : channel being shifted out in the current frame
//   oFRAME_DONE   : one-clk pulse when a full frame has been clocked
//   oFRAME_CNT    : completed-frame counter (wraps)
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  iRST,
  adc_spi_responder_if.slave    spi,
  input  logic                  iWR,
  input  logic [2:0]            iWR_ADDR,
  input  logic [DATA_W-1:0]     iWR_DATA,
  output logic [2:0]            oCH,
  output logic                  oFRAME_DONE,
  output logic [15:0]           oFRAME_CNT
);
  localparam int FRAME = LEAD_ZEROS + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] FULL       = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] ADDR_FIRST = CNT_W'(2);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(4);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Synchronisers and edge detectors are deliberately left out of reset so
  // they keep tracking the pins; a CS held low across reset therefore does
  // not look like a fresh falling edge.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_din_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk, w_cs, w_din;
  logic                   w_rise_sclk, w_fall_sclk, w_rise_cs, w_fall_cs;

  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.iSCLK};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi.iCS_n};
    r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  spi.iDIN};
    r_sclk_d    <= w_sclk;
    r_cs_d      <= w_cs;
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_din       = r_din_sync[SYNC_STAGES-1];
  assign w_rise_sclk = w_sclk & ~r_sclk_d;
  assign w_fall_sclk = ~w_sclk & r_sclk_d;
  assign w_rise_cs   = w_cs & ~r_cs_d;
  assign w_fall_cs   = ~w_cs & r_cs_d;

  logic [DATA_W-1:0] r_bank [8];
  state_t            r_state;
  logic [FRAME-1:0]  r_shreg;
  logic [CNT_W-1:0]  r_rcnt;
  logic [2:0]        r_addr_sr;
  logic [2:0]        r_next_ch;
  logic [2:0]        r_ch;
  logic              r_dout, r_dout_en, r_frame_done;
  logic [15:0]       r_frame_cnt;

  logic [DATA_W-1:0] w_load_data;
  logic [FRAME-1:0]  w_load_word;
  logic              w_start;

  // A bank write to the channel being loaded this cycle is forwarded.
  always_comb begin
    w_load_data = r_bank[r_next_ch];
    if (iWR && (iWR_ADDR == r_next_ch)) w_load_data = iWR_DATA;
  end
  assign w_load_word = {{LEAD_ZEROS{1'b0}}, w_load_data};

  // Frame start: CS fall from idle, or back-to-back frame in continuous mode
  // (falling SCLK after the last bit with CS still low).
  assign w_start = (r_state == IDLE) ? w_fall_cs
                 : (!w_rise_cs && w_fall_sclk && (r_rcnt == FULL) && !w_cs);

  always_ff @(posedge clk) begin
    if (iRST) begin
      for (int unsigned i = 0; i < 8; i++) r_bank[i] <= '0;
    end else if (iWR) begin
      r_bank[iWR_ADDR] <= iWR_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (iRST) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_rcnt       <= '0;
      r_addr_sr    <= '0;
      r_next_ch    <= '0;
      r_ch         <= '0;
      r_dout       <= 1'b0;
      r_dout_en    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) begin
        r_state   <= ACTIVE;
        r_shreg   <= w_load_word;
        r_ch      <= r_next_ch;
        r_dout    <= w_load_word[FRAME-1];
        r_dout_en <= 1'b1;
        r_rcnt    <= '0;
        r_addr_sr <= '0;
      end else if (r_state == ACTIVE) begin
        // CS rise has priority over any SCLK edge in the same cycle.
        if (w_rise_cs) begin
          r_state   <= IDLE;
          r_dout_en <= 1'b0;
          r_dout    <= 1'b0;
        end else if (w_rise_sclk) begin
          if (r_rcnt != FULL) begin
            r_rcnt <= r_rcnt + 1'b1;
            if ((r_rcnt >= ADDR_FIRST) && (r_rcnt <= ADDR_LAST))
              r_addr_sr <= {r_addr_sr[1:0], w_din};
            if (r_rcnt == LAST) begin
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + 16'd1;
              r_next_ch    <= r_addr_sr;
            end
          end
        end else if (w_fall_sclk && (r_rcnt != FULL)) begin
          r_shreg <= {r_shreg[FRAME-2:0], 1'b0};
          r_dout  <= r_shreg[FRAME-2];
        end
      end
    end
  end

  assign spi.oDOUT    = r_dout;
  assign spi.oDOUT_EN = r_dout_en;
  assign oCH          = r_ch;
  assign oFRAME_DONE  = r_frame_done;
  assign oFRAME_CNT   = r_frame_cnt;
endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;
  localparam int HALF = 6;   // SCLK half period in clk cycles (clk/12)

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic        iWR = 1'b0;
  logic [2:0]  iWR_ADDR = '0;
  logic [11:0] iWR_DATA = '0;
  logic [2:0]  oCH;
  logic        oFRAME_DONE;
  logic [15:0] oFRAME_CNT;

  adc_spi_responder_if spi();

  always #5 clk = ~clk;

  adc_spi_responder #(.DATA_W(12), .LEAD_ZEROS(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .iRST        (iRST),
    .spi         (spi),
    .iWR         (iWR),
    .iWR_ADDR    (iWR_ADDR),
    .iWR_DATA    (iWR_DATA),
    .oCH         (oCH),
    .oFRAME_DONE (oFRAME_DONE),
    .oFRAME_CNT  (oFRAME_CNT)
  );

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  // Reference model: sample bank, channel selected for next frame, frame count.
  logic [11:0] m_bank [8];
  logic [2:0]  m_next;
  logic [15:0] m_cnt;

  typedef struct {
    logic [2:0]  addr;
    int          nbits;
    logic [11:0] exp_data;
    logic [2:0]  exp_ch;
    int          exp_done;
    logic [15:0] exp_cnt;
  } vec_t;

  always @(negedge clk) if (oFRAME_DONE) done_seen++;

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    m_next = '0;
    m_cnt  = '0;
  endtask

  task automatic bank_write(input logic [2:0] a, input logic [11:0] d);
    @(negedge clk);
    iWR = 1'b1; iWR_ADDR = a; iWR_DATA = d;
    @(negedge clk);
    iWR = 1'b0;
    m_bank[a] = d;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi.iCS_n = 1'b0;
  endtask

  // Raise CS after the last falling SCLK; output must be released within
  // SYNC_STAGES+2 clk.
  task automatic cs_high(input string nm);
    repeat (2) @(negedge clk);
    spi.iCS_n = 1'b1;
    repeat (4) @(negedge clk);
    check({nm, ".en_off"}, 32'(spi.oDOUT_EN), 32'd0);
    check({nm, ".dout_off"}, 32'(spi.oDOUT), 32'd0);
    repeat (HALF - 4) @(negedge clk);
  endtask

  // Clock nbits SCLK periods (idle low). DOUT bit b is sampled at the end of
  // the low phase preceding rising edge b+1. Address bits go out on rises 3..5.
  task automatic run_bits(input logic [2:0] addr, input int nbits, input int wr_at,
                          input logic [2:0] wa, input logic [11:0] wd,
                          output logic [15:0] word, output logic [2:0] ch,
                          output logic en_and, output logic en_or);
    word = '0; ch = '0; en_and = 1'b1; en_or = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      if (b + 1 >= 3 && b + 1 <= 5) spi.iDIN = addr[5 - (b + 1)];
      else spi.iDIN = 1'($urandom);
      if (b == wr_at) begin
        bank_write(wa, wd);
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      word[15 - b] = spi.oDOUT;
      en_and = en_and & spi.oDOUT_EN;
      en_or  = en_or | spi.oDOUT_EN;
      if (b == 0) ch = oCH;
      spi.iSCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.iSCLK = 1'b0;
    end
  endtask

  task automatic shift_frame(input string nm, input logic [2:0] addr, input int nbits,
                             input int wr_at, input logic [2:0] wa, input logic [11:0] wd,
                             output logic [15:0] word, output logic [2:0] ch, output int dn);
    int d0;
    logic ea, eo;
    d0 = done_seen;
    cs_low();
    run_bits(addr, nbits, wr_at, wa, wd, word, ch, ea, eo);
    check({nm, ".en_on"}, 32'(ea), 32'd1);
    cs_high(nm);
    dn = done_seen - d0;
  endtask

  // Model-checked frame: expected word is the bank value of the selected
  // channel at frame start; a complete frame advances count and selection.
  task automatic frame(input string nm, input logic [2:0] addr, input int nbits,
                       input int wr_at, input logic [2:0] wa, input logic [11:0] wd);
    logic [15:0] w, exp_w;
    logic [2:0]  ch, exp_ch;
    int dn, sh;
    exp_w  = {4'b0, m_bank[m_next]};
    exp_ch = m_next;
    shift_frame(nm, addr, nbits, wr_at, wa, wd, w, ch, dn);
    if (nbits == 16) begin
      m_cnt  = m_cnt + 16'd1;
      m_next = addr;
    end
    sh = 16 - nbits;
    check({nm, ".data"}, 32'(w >> sh), 32'(exp_w >> sh));
    check({nm, ".ch"}, 32'(ch), 32'(exp_ch));
    check({nm, ".done"}, 32'(dn), (nbits == 16) ? 32'd1 : 32'd0);
    check({nm, ".cnt"}, 32'(oFRAME_CNT), 32'(m_cnt));
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] w, w2, e1, e2;
    logic [2:0]  ch, ch2;
    logic        ea, eo;
    int          dn, d0, nb, wr_at;

    spi.iSCLK = 1'b0; spi.iCS_n = 1'b1; spi.iDIN = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst.dout", 32'(spi.oDOUT), 32'd0);
    check("rst.en", 32'(spi.oDOUT_EN), 32'd0);
    check("rst.ch", 32'(oCH), 32'd0);
    check("rst.done", 32'(oFRAME_DONE), 32'd0);
    check("rst.cnt", 32'(oFRAME_CNT), 32'd0);
    iRST = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    bank_write(3'd0, 12'hABC);
    bank_write(3'd5, 12'h123);
    bank_write(3'd2, 12'hFFF);

    // Directed frame table (abort entry compares only the bits clocked out)
    tbl[0] = '{3'd5, 16, 12'hABC, 3'd0, 1, 16'd1};
    tbl[1] = '{3'd0, 16, 12'h123, 3'd5, 1, 16'd2};
    tbl[2] = '{3'd3,  7, 12'hABC, 3'd0, 0, 16'd2};
    tbl[3] = '{3'd2, 16, 12'hABC, 3'd0, 1, 16'd3};
    tbl[4] = '{3'd7, 16, 12'hFFF, 3'd2, 1, 16'd4};
    tbl[5] = '{3'd0, 16, 12'h000, 3'd7, 1, 16'd5};
    for (int i = 0; i < 6; i++) begin
      shift_frame("tbl", tbl[i].addr, tbl[i].nbits, -1, 3'd0, 12'd0, w, ch, dn);
      check("tbl.data", 32'(w >> (16 - tbl[i].nbits)),
            32'({4'b0, tbl[i].exp_data} >> (16 - tbl[i].nbits)));
      check("tbl.ch", 32'(ch), 32'(tbl[i].exp_ch));
      check("tbl.done", 32'(dn), 32'(tbl[i].exp_done));
      check("tbl.cnt", 32'(oFRAME_CNT), 32'(tbl[i].exp_cnt));
      if (tbl[i].nbits == 16) m_next = tbl[i].addr;
    end
    m_cnt = 16'd5;

    // Continuous mode: 32 SCLKs under one CS, addresses 5 then 2
    e1 = {4'b0, m_bank[m_next]};
    e2 = {4'b0, m_bank[5]};
    d0 = done_seen;
    cs_low();
    run_bits(3'd5, 16, -1, 3'd0, 12'd0, w, ch, ea, eo);
    run_bits(3'd2, 16, -1, 3'd0, 12'd0, w2, ch2, ea, eo);
    check("cont.en_nogap", 32'(ea), 32'd1);
    cs_high("cont");
    check("cont.data1", 32'(w), 32'(e1));
    check("cont.ch1", 32'(ch), 32'd0);
    check("cont.data2", 32'(w2), 32'h0123);
    check("cont.ch2", 32'(ch2), 32'd5);
    check("cont.done", 32'(done_seen - d0), 32'd2);
    m_cnt = m_cnt + 16'd2;
    m_next = 3'd2;
    check("cont.cnt", 32'(oFRAME_CNT), 32'(m_cnt));

    // Write during a frame does not affect the word being shifted
    frame("mw0", 3'd5, 16, -1, 3'd0, 12'd0);
    frame("mw1", 3'd5, 16, 6, 3'd5, 12'h555);
    frame("mw2", 3'd5, 16, -1, 3'd0, 12'd0);
    check("mw2.bankval", 32'(m_bank[5]), 32'h555);

    // Write landing on the exact load cycle (third clk after CS fall) is used
    d0 = done_seen;
    @(negedge clk); spi.iCS_n = 1'b0;
    @(negedge clk); @(negedge clk);
    iWR = 1'b1; iWR_ADDR = 3'd5; iWR_DATA = 12'h777;
    @(negedge clk); iWR = 1'b0;
    m_bank[5] = 12'h777;
    run_bits(3'd1, 16, -1, 3'd0, 12'd0, w, ch, ea, eo);
    cs_high("byp");
    check("byp.data", 32'(w), 32'h0777);
    check("byp.ch", 32'(ch), 32'd5);
    m_next = 3'd1; m_cnt = m_cnt + 16'd1;
    check("byp.done", 32'(done_seen - d0), 32'd1);

    // CS and SCLK rise together on the 16th edge: CS wins, frame aborted
    d0 = done_seen;
    cs_low();
    run_bits(3'd6, 15, -1, 3'd0, 12'd0, w, ch, ea, eo);
    repeat (HALF) @(negedge clk);
    spi.iSCLK = 1'b1; spi.iCS_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi.iSCLK = 1'b0;
    repeat (HALF) @(negedge clk);
    check("simul.done", 32'(done_seen - d0), 32'd0);
    check("simul.cnt", 32'(oFRAME_CNT), 32'(m_cnt));
    check("simul.en", 32'(spi.oDOUT_EN), 32'd0);
    frame("simul.next", 3'd3, 16, -1, 3'd0, 12'd0);

    // Reset at rcnt=9 with CS held low
    cs_low();
    run_bits(3'd4, 9, -1, 3'd0, 12'd0, w, ch, ea, eo);
    @(negedge clk); iRST = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst.dout", 32'(spi.oDOUT), 32'd0);
    check("mrst.en", 32'(spi.oDOUT_EN), 32'd0);
    check("mrst.ch", 32'(oCH), 32'd0);
    check("mrst.done", 32'(oFRAME_DONE), 32'd0);
    check("mrst.cnt", 32'(oFRAME_CNT), 32'd0);
    iRST = 1'b0;
    model_reset();
    run_bits(3'd4, 4, -1, 3'd0, 12'd0, w, ch, ea, eo);
    check("mrst.stay_idle", 32'(eo), 32'd0);
    cs_high("mrst");
    frame("mrst.post", 3'd1, 16, -1, 3'd0, 12'd0);

    // Randomized frames, writes and aborts against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) bank_write(3'($urandom_range(0, 7)), 12'($urandom));
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
      wr_at = (nb >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb - 1)) : -1;
      frame("rnd", 3'($urandom_range(0, 7)), nb, wr_at,
            3'($urandom_range(0, 7)), 12'($urandom));
    end

    // Counter wrap
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    m_cnt = 16'hFFFF;
    frame("wrap", 3'd0, 16, -1, 3'd0, 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
